// File: rtl/aib_tx_flit_arbiter_if.sv
// Bus bundle for aib_tx_flit_arbiter: VC request streams, credit return, flit output.
// slave = arbiter side, master = core/adapter side.
interface aib_tx_flit_arbiter_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH-1:0]    i_ch_valid;
    logic [NUM_CH-1:0]    o_ch_ready;
    logic [NUM_CH*64-1:0] i_ch_data;
    logic                 i_credit_valid;
    logic [3:0]           i_credit_ch;
    logic                 o_tx_valid;
    logic                 i_tx_ready;
    logic [71:0]          o_tx_data;
    logic [NUM_CH-1:0]    o_credit_avail;
    logic                 o_credit_err;

    modport slave (
        input  i_ch_valid, i_ch_data, i_credit_valid, i_credit_ch, i_tx_ready,
        output o_ch_ready, o_tx_valid, o_tx_data, o_credit_avail, o_credit_err
    );

    modport master (
        output i_ch_valid, i_ch_data, i_credit_valid, i_credit_ch, i_tx_ready,
        input  o_ch_ready, o_tx_valid, o_tx_data, o_credit_avail, o_credit_err
    );
endinterface

// File: rtl/aib_tx_flit_arbiter.sv
// Round-robin, credit-gated merge of NUM_CH 64-bit VC streams into one 72-bit flit stream.
// Optional AIB_FLIT_PARITY_EN: bit 70 carries even parity over the flit.
module aib_tx_flit_arbiter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CREDIT_W     = 4,
    parameter int unsigned INIT_CREDITS = 8
) (
    input logic                   i_bus_clk,
    input logic                   i_rst_n,
    aib_tx_flit_arbiter_if.slave  bus
);
    localparam int unsigned         PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDITS);

    logic                tx_valid_q, tx_valid_d;
    logic [71:0]         tx_data_q, tx_data_d;
    logic                credit_err_q, credit_err_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_W-1:0] credit_q [NUM_CH];
    logic [CREDIT_W-1:0] credit_d [NUM_CH];

    logic                load_en;
    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   grant;
    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    scan_idx;
    logic [63:0]         grant_data;
    logic [3:0]          grant_ch;
    logic                parity;
    logic [NUM_CH-1:0]   credit_avail;

    assign load_en = !tx_valid_q || bus.i_tx_ready;

    always_comb begin
        eligible     = '0;
        credit_avail = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            credit_avail[i] = (credit_q[i] != '0);
            eligible[i]     = bus.i_ch_valid[i] && credit_avail[i];
        end
    end

    // Upward scan from the pointer; the first eligible hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        grant       = '0;
        if (load_en) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                scan_idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_CH);
                if (!grant_found && eligible[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign grant_data = bus.i_ch_data[64*32'(grant_idx) +: 64];
    assign grant_ch   = 4'(grant_idx);

`ifdef AIB_FLIT_PARITY_EN
    assign parity = ^{2'b00, grant_ch, grant_data};
`else
    assign parity = 1'b0;
`endif

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rr_ptr_d   = rr_ptr_q;
        if (load_en) begin
            tx_valid_d = grant_found;
            if (grant_found) begin
                tx_data_d = {1'b1, parity, 2'b00, grant_ch, grant_data};
                rr_ptr_d  = PTR_W'((32'(grant_idx) + 1) % NUM_CH);
            end
        end
    end

    // A return and a grant on the same channel cancel; returns to a full counter are dropped.
    always_comb begin
        credit_err_d = credit_err_q;
        if (bus.i_credit_valid && (32'(bus.i_credit_ch) >= NUM_CH)) begin
            credit_err_d = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            credit_d[i] = credit_q[i];
            if (bus.i_credit_valid && (32'(bus.i_credit_ch) == i) && (credit_q[i] == INIT_C)) begin
                credit_err_d = 1'b1;
            end
            case ({bus.i_credit_valid && (32'(bus.i_credit_ch) == i) && (credit_q[i] != INIT_C),
                   grant[i]})
                2'b10:   credit_d[i] = credit_q[i] + 1'b1;
                2'b01:   credit_d[i] = credit_q[i] - 1'b1;
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    always_ff @(posedge i_bus_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            credit_err_q <= 1'b0;
            rr_ptr_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                credit_q[i] <= INIT_C;
            end
        end else begin
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            credit_err_q <= credit_err_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign bus.o_ch_ready     = grant & {NUM_CH{i_rst_n}};
    assign bus.o_tx_valid     = tx_valid_q;
    assign bus.o_tx_data      = tx_data_q;
    assign bus.o_credit_avail = credit_avail;
    assign bus.o_credit_err   = credit_err_q;
endmodule
